booth_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier for 6-bit signed two's-complement operands, producing a 12-bit signed product. Both operands arrive over a shared 6-bit input bus after a start request. The product leaves over a 6-bit output bus in two consecutive beats, high half first. It sits as a slave arithmetic unit behind a narrow-bus controller that drives the load/compute/read sequence.

---
 rtl/booth_multiplier.sv | 117 +++++++++++
 tb/tb_booth_multiplier.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier: 6-bit signed X and Y loaded over a shared bus,
// 12-bit product returned as two 6-bit beats (high half first, flagged by done).
module booth_multiplier (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] inBus,
  output logic [5:0] outBus,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_X = 3'd1,
    LOAD_Y = 3'd2,
    CALC   = 3'd3,
    OUT_HI = 3'd4,
    OUT_LO = 3'd5
  } state_t;

  state_t      state_r;
  logic [5:0]  m_r;
  logic [6:0]  a_r;
  logic [5:0]  q_r;
  logic        q_m1_r;
  logic [2:0]  count_r;
  logic [13:0] step_s;

  // One Booth step: conditional add/sub of sign-extended M, then arithmetic
  // shift of {A,Q,Q-1}. Result packs the new {A[6:0], Q[5:0], Q-1}.
  function automatic logic [13:0] booth_step(
    input logic [6:0] a,
    input logic [5:0] q,
    input logic       q_m1,
    input logic [5:0] m
  );
    logic [6:0] m_ext;
    logic [6:0] sum;
    m_ext = {m[5], m};
    case ({q[0], q_m1})
      2'b10:   sum = a - m_ext;
      2'b01:   sum = a + m_ext;
      default: sum = a;
    endcase
    return {sum[6], sum, q};
  endfunction

  assign step_s = booth_step(a_r, q_r, q_m1_r, m_r);

  // Control FSM, datapath registers and registered Moore outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      m_r     <= 6'd0;
      a_r     <= 7'd0;
      q_r     <= 6'd0;
      q_m1_r  <= 1'b0;
      count_r <= 3'd0;
      outBus  <= 6'd0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          outBus <= 6'd0;
          done   <= 1'b0;
          if (start) begin
            state_r <= LOAD_X;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD_X: begin
          m_r     <= inBus;
          state_r <= LOAD_Y;
        end
        LOAD_Y: begin
          q_r     <= inBus;
          a_r     <= 7'd0;
          q_m1_r  <= 1'b0;
          count_r <= 3'd0;
          state_r <= CALC;
        end
        CALC: begin
          a_r     <= step_s[13:7];
          q_r     <= step_s[6:1];
          q_m1_r  <= step_s[0];
          count_r <= count_r + 3'd1;
          // The last step's result goes straight into the high beat so it is
          // on outBus in the first OUT_HI cycle.
          if (count_r == 3'd5) begin
            state_r <= OUT_HI;
            outBus  <= step_s[12:7];
            done    <= 1'b1;
          end else begin
            state_r <= CALC;
          end
        end
        OUT_HI: begin
          outBus  <= q_r;
          done    <= 1'b0;
          state_r <= OUT_LO;
        end
        OUT_LO: begin
          outBus  <= 6'd0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          outBus  <= 6'd0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: products predicted at Y-load time,
// compared beat by beat when done rises.
module tb_booth_multiplier;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [5:0] inBus = 6'd0;
  logic [5:0] outBus;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_p;
  logic [5:0]  exp_lo;
  bit          mon_lo = 1'b0;

  booth_multiplier dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inBus (inBus),
    .outBus(outBus),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on the high beat, checks the low beat next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        mon_lo = 1'b0;
      end else if (mon_lo) begin
        check_eq("lo_beat", outBus, exp_lo);
        check_eq("done_one_cycle", done, 1'b0);
        mon_lo = 1'b0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", done, 1'b0);
        end else begin
          mon_p = exp_q.pop_front();
          check_eq("hi_beat", outBus, mon_p[11:6]);
          exp_lo = mon_p[5:0];
          mon_lo = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns just after edge 3 (Y captured).
  task automatic launch(input logic [5:0] x, input logic [5:0] y, input bit hold_start);
    int xi;
    int yi;
    xi = int'($signed(x));
    yi = int'($signed(y));
    start = 1'b1;
    inBus = 6'($urandom);
    @(posedge clk);
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    inBus = x;
    @(posedge clk);
    @(negedge clk);
    inBus = y;
    exp_q.push_back(12'(xi * yi));
    @(posedge clk);
  endtask

  // From just after edge 3 to the negedge after edge 11.
  task automatic finish_op();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("early_done", done, 1'b0);
      @(posedge clk);
    end
    @(negedge clk);
    check_eq("latency_done", done, 1'b1);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("idle_outbus", outBus, 6'd0);
    check_eq("idle_done", done, 1'b0);
    start = 1'b0;
  endtask

  task automatic run_op(input logic [5:0] x, input logic [5:0] y, input bit hold_start);
    launch(x, y, hold_start);
    finish_op();
  endtask

  // Asynchronous reset k edges after Y capture; outputs must clear without a clock edge.
  task automatic abort_op(input logic [5:0] x, input logic [5:0] y, input int k);
    launch(x, y, 1'b0);
    repeat (k) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_eq("abort_outbus", outBus, 6'd0);
    check_eq("abort_done", done, 1'b0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1;
    check_eq("reset_outbus", outBus, 6'd0);
    check_eq("reset_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_op(6'd9, 6'd8, 1'b0);
    abort_op(6'd9, 6'd8, 2);
    run_op(6'd9, 6'd8, 1'b0);
    run_op(6'd23, 6'(-11), 1'b0);
    run_op(6'(-10), 6'(-19), 1'b0);
    run_op(6'd20, 6'd0, 1'b0);
    run_op(6'd31, 6'(-31), 1'b0);
    run_op(6'(-32), 6'(-32), 1'b0);
    run_op(6'(-32), 6'd31, 1'b0);
    abort_op(6'd13, 6'(-5), 6);
    run_op(6'd5, 6'(-7), 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_eq("single_product", done, 1'b0);
    end

    // Exhaustive sweep, back-to-back: each launch samples start at edge 12 of the previous op.
    for (int x = 0; x < 64; x++) begin
      for (int y = 0; y < 64; y++) begin
        run_op(6'(x), 6'(y), 1'b0);
      end
    end

    repeat (3) @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
